// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum streamer: FSM encoding, default sizing
// and the magnitude scaler used when samples are written into frame storage.
package spectrum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int DEFAULT_OUT_BINS = 512;
  localparam int DEFAULT_GAP      = 4;
  localparam int SAT_MAX          = 511;

  // Right-shift then clamp into the 9-bit range the downstream logic expects.
  function automatic logic [8:0] scale_mag(input logic [31:0] mag, input logic [3:0] sh);
    logic [31:0] s;
    s = mag >> sh;
    return (s > 32'(SAT_MAX)) ? 9'(SAT_MAX) : s[8:0];
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one read port with a
// registered read. Contents are never reset; validity is tracked outside.
module frame_ram #(
  parameter int DEPTH = 512,
  parameter int DW    = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/spectrum_streamer.sv
// Captures one FFT magnitude frame, then replays it as a contiguous burst of
// scaled 9-bit bins followed by a fixed idle gap; frames arriving mid-burst are dropped.
module spectrum_streamer
  import spectrum_pkg::*;
#(
  parameter int DW_IN    = 16,
  parameter int OUT_BINS = DEFAULT_OUT_BINS,
  parameter int GAP      = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW_IN-1:0] mag_in,
  input  logic             mag_valid,
  input  logic             mag_last,
  input  logic [3:0]       shift,
  output logic [8:0]       wdata,
  output logic             wvalid,
  output logic             wlast,
  output logic             busy,
  output logic             frame_drop
);

  localparam int AW = $clog2(OUT_BINS);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP + 1);
  localparam logic [CW-1:0] BINS = CW'(OUT_BINS);

  state_t        state_reg, state_next;
  logic [CW-1:0] bin_cnt_reg, bin_cnt_next;
  logic [CW-1:0] len_reg, len_next;
  logic [CW-1:0] rd_cnt_reg, rd_cnt_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic          discard_reg, discard_next;
  logic          rd_valid_reg, rd_last_reg, frame_drop_reg;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic          ram_re;
  logic          rd_is_last;
  logic          drop_start;
  logic [8:0]    scaled;
  logic [8:0]    ram_q;

  assign scaled = scale_mag(32'(mag_in), shift);

  frame_ram #(
    .DEPTH(OUT_BINS),
    .DW   (9),
    .AW   (AW)
  ) u_frame_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(scaled),
    .re   (ram_re),
    .raddr(rd_cnt_reg[AW-1:0]),
    .rdata(ram_q)
  );

  always_comb begin
    state_next   = state_reg;
    bin_cnt_next = bin_cnt_reg;
    len_next     = len_reg;
    rd_cnt_next  = rd_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    discard_next = discard_reg;
    ram_we       = 1'b0;
    ram_waddr    = bin_cnt_reg[AW-1:0];
    ram_re       = 1'b0;
    rd_is_last   = 1'b0;
    drop_start   = 1'b0;

    // Discard tracking is independent of state: a dropped frame is swallowed
    // up to its own last sample, even if the burst finishes meanwhile.
    if (mag_valid && (discard_reg || state_reg == ST_DRAIN || state_reg == ST_GAP)) begin
      drop_start   = !discard_reg;
      discard_next = !mag_last;
    end

    case (state_reg)
      ST_IDLE: begin
        bin_cnt_next = '0;
        if (mag_valid && !discard_reg) begin
          ram_we       = 1'b1;
          ram_waddr    = '0;
          bin_cnt_next = CW'(1);
          if (mag_last) begin
            len_next    = CW'(1);
            rd_cnt_next = '0;
            state_next  = ST_DRAIN;
          end else begin
            state_next  = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (mag_valid) begin
          // Saturating count keeps oversize frames from wrapping onto bin 0.
          ram_we       = (bin_cnt_reg < BINS);
          bin_cnt_next = (bin_cnt_reg < BINS) ? bin_cnt_reg + 1'b1 : bin_cnt_reg;
          if (mag_last) begin
            len_next    = (bin_cnt_reg < BINS) ? bin_cnt_reg + 1'b1 : BINS;
            rd_cnt_next = '0;
            state_next  = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (rd_cnt_reg < len_reg) begin
          ram_re      = 1'b1;
          rd_is_last  = (rd_cnt_reg == len_reg - 1'b1);
          rd_cnt_next = rd_cnt_reg + 1'b1;
        end
        if (rd_last_reg) begin
          gap_cnt_next = '0;
          state_next   = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg == GW'(GAP - 1)) begin
          bin_cnt_next = '0;
          state_next   = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      bin_cnt_reg    <= '0;
      len_reg        <= '0;
      rd_cnt_reg     <= '0;
      gap_cnt_reg    <= '0;
      discard_reg    <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      frame_drop_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bin_cnt_reg    <= bin_cnt_next;
      len_reg        <= len_next;
      rd_cnt_reg     <= rd_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      discard_reg    <= discard_next;
      rd_valid_reg   <= ram_re;
      rd_last_reg    <= rd_is_last;
      frame_drop_reg <= drop_start;
    end
  end

  // RAM output is unreset, so it is masked by the reset-cleared valid flag.
  assign wvalid     = rd_valid_reg;
  assign wlast      = rd_last_reg;
  assign wdata      = rd_valid_reg ? ram_q : 9'd0;
  assign busy       = (state_reg != ST_IDLE);
  assign frame_drop = frame_drop_reg;

endmodule

// File: tb/tb_spectrum_streamer.sv
// Directed bench for spectrum_streamer: a vector table of single-bin frames
// plus hand-written multi-cycle sequences for long, oversize, dropped and reset cases.
module tb_spectrum_streamer;

  localparam int GAP_C = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] mag_in;
  logic        mag_valid;
  logic        mag_last;
  logic [3:0]  shift;
  logic [8:0]  wdata;
  logic        wvalid;
  logic        wlast;
  logic        busy;
  logic        frame_drop;

  spectrum_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mag_in    (mag_in),
    .mag_valid (mag_valid),
    .mag_last  (mag_last),
    .shift     (shift),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wlast     (wlast),
    .busy      (busy),
    .frame_drop(frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int out_q[$];
  int last_q[$];
  int cyc_q[$];
  int exp_q[$];
  int drop_cnt = 0;
  int busy_fall_cyc = -1;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc++;

  // Output monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (wvalid) begin
      out_q.push_back(int'(wdata));
      last_q.push_back(int'(wlast));
      cyc_q.push_back(cyc);
    end else begin
      total++;
      if (wdata !== 9'd0 || wlast !== 1'b0) begin
        bad++;
        $display("FAIL idle_outputs cyc=%0d got wdata=%0d wlast=%0b want 0/0", cyc, wdata, wlast);
      end
    end
    if (frame_drop) drop_cnt++;
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  typedef struct {
    logic [15:0] mag;
    logic [3:0]  sh;
    int          exp;
  } vec_t;

  vec_t vecs[9];

  task automatic put(input logic v, input logic l, input logic [15:0] m, input logic [3:0] s);
    mag_valid = v;
    mag_last  = l;
    mag_in    = m;
    shift     = s;
    @(posedge clk);
    #1;
    mag_valid = 1'b0;
    mag_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic clear_q();
    out_q.delete();
    last_q.delete();
    cyc_q.delete();
    busy_fall_cyc = -1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #2;
      if (!busy) break;
      n++;
    end
    @(negedge clk);
    #1;
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout busy still high after %0d cycles", name, n);
    end
  endtask

  function automatic int first_data_mismatch();
    if (out_q.size() != exp_q.size()) return 0;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] != exp_q[i]) return i;
    return -1;
  endfunction

  // Full check of one frame burst: length, data, wlast, latency/contiguity, gap.
  task automatic run_check(input string name, input int l_cyc);
    int mi;
    int lastpos;
    int contig;
    wait_idle(name);
    check({name, "_len"}, out_q.size(), exp_q.size());
    mi = first_data_mismatch();
    total++;
    if (mi >= 0) begin
      bad++;
      if (mi < out_q.size() && mi < exp_q.size())
        $display("FAIL %s_data idx=%0d got=%0d want=%0d", name, mi, out_q[mi], exp_q[mi]);
      else
        $display("FAIL %s_data got %0d bins want %0d", name, out_q.size(), exp_q.size());
    end
    lastpos = -1;
    for (int i = 0; i < last_q.size(); i++)
      if (last_q[i] != 0) lastpos = (lastpos == -1) ? i : -2;
    check({name, "_wlast_pos"}, lastpos, exp_q.size() - 1);
    contig = 1;
    for (int i = 0; i < cyc_q.size(); i++)
      if (cyc_q[i] != l_cyc + 1 + i) contig = 0;
    check({name, "_latency_contig"}, contig, 1);
    if (cyc_q.size() > 0)
      check({name, "_gap"}, busy_fall_cyc, cyc_q[cyc_q.size()-1] + GAP_C + 1);
    clear_q();
  endtask

  int l_cyc;
  int sz;
  int mi;

  initial begin
    vecs[0] = '{16'hFFFF, 4'd0,  511};
    vecs[1] = '{16'd1000, 4'd2,  250};
    vecs[2] = '{16'd511,  4'd0,  511};
    vecs[3] = '{16'd512,  4'd0,  511};
    vecs[4] = '{16'd512,  4'd1,  256};
    vecs[5] = '{16'hFFFF, 4'd15, 1};
    vecs[6] = '{16'd0,    4'd0,  0};
    vecs[7] = '{16'h8000, 4'd6,  511};
    vecs[8] = '{16'h8000, 4'd7,  256};

    rst_n = 1'b0;
    mag_in = '0;
    mag_valid = 1'b0;
    mag_last = 1'b0;
    shift = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_wdata", int'(wdata), 0);
    check("rst_wvalid", int'(wvalid), 0);
    check("rst_wlast", int'(wlast), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_drop", int'(frame_drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    clear_q();

    // Single-bin frames exercising the scaler and the len=1 path.
    for (int v = 0; v < 9; v++) begin
      exp_q.delete();
      exp_q.push_back(vecs[v].exp);
      put(1'b1, 1'b1, vecs[v].mag, vecs[v].sh);
      l_cyc = cyc;
      run_check($sformatf("vec%0d", v), l_cyc);
    end

    // 512-sample ramp.
    exp_q.delete();
    for (int k = 0; k < 512; k++) begin
      exp_q.push_back(k);
      put(1'b1, k == 511, 16'(k * 2), 4'd1);
    end
    l_cyc = cyc;
    run_check("ramp512", l_cyc);

    // Oversize frame: only first 512 bins, bin 0 intact.
    exp_q.delete();
    for (int k = 0; k < 1024; k++) begin
      if (k < 512) exp_q.push_back((k * 3 > 511) ? 511 : k * 3);
      put(1'b1, k == 1023, 16'(k * 3), 4'd0);
    end
    l_cyc = cyc;
    run_check("oversize", l_cyc);

    // Short frame with valid gaps.
    exp_q.delete();
    exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30);
    put(1'b1, 1'b0, 16'd10, 4'd0);
    idle_cycles(2);
    put(1'b1, 1'b0, 16'd20, 4'd0);
    idle_cycles(1);
    put(1'b1, 1'b1, 16'd30, 4'd0);
    l_cyc = cyc;
    run_check("short3", l_cyc);
    check("no_drop_yet", drop_cnt, 0);

    // Second frame during DRAIN is dropped; third streams normally.
    exp_q.delete();
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(k + 100);
      put(1'b1, k == 19, 16'(k + 100), 4'd0);
    end
    l_cyc = cyc;
    idle_cycles(5);
    for (int k = 0; k < 5; k++) put(1'b1, k == 4, 16'hABCD, 4'd0);
    run_check("dropA", l_cyc);
    check("drop_pulses_1", drop_cnt, 1);
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(7 * k + 1);
      put(1'b1, k == 3, 16'(7 * k + 1), 4'd0);
    end
    l_cyc = cyc;
    run_check("afterdrop", l_cyc);

    // Dropped frame outliving the burst into IDLE; its last must not start FILL.
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(k);
      put(1'b1, k == 7, 16'(k * 4), 4'd2);
    end
    idle_cycles(3);
    for (int k = 0; k < 40; k++) put(1'b1, k == 39, 16'd300, 4'd0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(k + 5);
      put(1'b1, k == 2, 16'(k + 5), 4'd0);
    end
    wait_idle("longdrop");
    check("longdrop_len", out_q.size(), 11);
    mi = first_data_mismatch();
    check("longdrop_data_first_bad", mi, -1);
    sz = 0;
    for (int i = 0; i < last_q.size(); i++)
      if (last_q[i] != 0 && (i == 7 || i == 10)) sz++;
      else if (last_q[i] != 0) sz += 100;
    check("longdrop_wlasts", sz, 2);
    check("drop_pulses_2", drop_cnt, 2);
    clear_q();

    // Reset pulse mid-DRAIN.
    for (int k = 0; k < 200; k++) put(1'b1, k == 199, 16'(k), 4'd0);
    sz = 0;
    while (out_q.size() < 101 && sz < 400) begin
      @(posedge clk);
      sz++;
    end
    check("pre_reset_bins_reached", (out_q.size() >= 101) ? 1 : 0, 1);
    mi = -1;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] != i && mi < 0) mi = i;
    check("pre_reset_data_first_bad", mi, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wvalid", int'(wvalid), 0);
    check("mid_rst_wdata", int'(wdata), 0);
    check("mid_rst_wlast", int'(wlast), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    sz = out_q.size();
    idle_cycles(300);
    check("post_rst_no_output", out_q.size(), sz);
    check("post_rst_busy", int'(busy), 0);
    clear_q();
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(k * 50);
      put(1'b1, k == 5, 16'(k * 100), 4'd1);
    end
    l_cyc = cyc;
    run_check("post_rst_frame", l_cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
